// File: rtl/byte_to_nibble_fifo.sv
// Width down-converting FIFO: bytes in, nibbles out, single clock, valid/enable handshakes.
// Build option NIBBLE_LSB_FIRST_EN emits the low nibble of each byte first.
module byte_to_nibble_fifo #(
  parameter int unsigned DEPTH = 8,  // bytes; power of 2, at least 2
  parameter int unsigned AW    = 3   // log2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_v,
  output logic          in_en,
  input  logic [7:0]    data_in,
  output logic          out_v,
  input  logic          out_en,
  output logic [3:0]    data_out,
  output logic [AW+1:0] level
);

  localparam logic [AW+1:0] InEnMax = (AW + 2)'(2 * DEPTH - 2);
  localparam logic [AW+1:0] CntOne  = (AW + 2)'(1);
  localparam logic [AW+1:0] CntTwo  = (AW + 2)'(2);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW+1:0] cnt;
  logic          wr_acc;
  logic          rd_acc;
  logic [7:0]    rd_byte;
  logic [3:0]    nib;

  always_comb begin
    // Write credit depends on cnt alone: a full free byte slot is required.
    in_en   = (cnt <= InEnMax);
    out_v   = (cnt != '0);
    level   = cnt;
    wr_acc  = in_v && in_en;
    rd_acc  = out_en && out_v;
    rd_byte = mem[rd_ptr[AW:1]];
`ifdef NIBBLE_LSB_FIRST_EN
    nib = rd_ptr[0] ? rd_byte[7:4] : rd_byte[3:0];
`else
    nib = rd_ptr[0] ? rd_byte[3:0] : rd_byte[7:4];
`endif
    data_out = out_v ? nib : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + (AW + 1)'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CntTwo;
        2'b01:   cnt <= cnt - CntOne;
        2'b11:   cnt <= cnt + CntOne;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_byte_to_nibble_fifo.sv
// Bench for byte_to_nibble_fifo: queue-of-nibbles model checked every cycle, plus directed
// literal expectations. Honours NIBBLE_LSB_FIRST_EN for nibble order.
module tb_byte_to_nibble_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
`ifdef NIBBLE_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_v;
  logic          in_en;
  logic [7:0]    data_in;
  logic          out_v;
  logic          out_en;
  logic [3:0]    data_out;
  logic [AW+1:0] level;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;
  logic [3:0] q[$];

  byte_to_nibble_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_v     (in_v),
    .in_en    (in_en),
    .data_in  (data_in),
    .out_v    (out_v),
    .out_en   (out_en),
    .data_out (data_out),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] first_nib(input logic [7:0] b);
    return LsbFirst ? b[3:0] : b[7:4];
  endfunction

  function automatic logic [3:0] second_nib(input logic [7:0] b);
    return LsbFirst ? b[7:4] : b[3:0];
  endfunction

  // Model: a nibble queue of capacity 2*DEPTH; writes need room for a whole byte.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        q.delete();
      end else begin
        automatic bit rd = out_en && (q.size() != 0);
        automatic bit wr = in_v && (q.size() <= 2 * DEPTH - 2);
        if (rd) void'(q.pop_front());
        if (wr) begin
          q.push_back(first_nib(data_in));
          q.push_back(second_nib(data_in));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("m_level", 32'(level), 32'(q.size()));
        check("m_in_en", 32'(in_en), 32'(q.size() <= 2 * DEPTH - 2));
        check("m_out_v", 32'(out_v), 32'(q.size() != 0));
        check("m_data_out", 32'(data_out), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        check("m_level_max", 32'(level <= 2 * DEPTH), 32'h1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_en = 1'b1;
    for (int k = 0; k < 64 && level != 0; k++) step();
    out_en = 1'b0;
    check("drain_empty", 32'(level), 32'h0);
  endtask

  initial begin
    rst = 1'b0; in_v = 1'b1; data_in = 8'hFF; out_en = 1'b0;
    // Reset held for two cycles with a write attempt active
    step();
    cmp_on = 1'b1;
    step();
    check("rst_in_en", 32'(in_en), 32'h1);
    check("rst_out_v", 32'(out_v), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    rst = 1'b1; in_v = 1'b0;
    step();
    check("rst_nothing_stored", 32'(level), 32'h0);

    // Single byte
    in_v = 1'b1; data_in = 8'hA5;
    step();
    in_v = 1'b0;
    check("single_level2", 32'(level), 32'h2);
    check("single_nib0", 32'(data_out), LsbFirst ? 32'h5 : 32'hA);
    out_en = 1'b1;
    step();
    check("single_level1", 32'(level), 32'h1);
    check("single_nib1", 32'(data_out), LsbFirst ? 32'hA : 32'h5);
    step();
    check("single_level0", 32'(level), 32'h0);
    check("single_out_v0", 32'(out_v), 32'h0);
    out_en = 1'b0;

    // Fill to full, then a dropped write
    for (int i = 0; i < 8; i++) begin
      in_v = 1'b1; data_in = 8'(8'h10 + i);
      step();
    end
    check("full_level", 32'(level), 32'd16);
    check("full_in_en", 32'(in_en), 32'h0);
    data_in = 8'h99;
    step();
    in_v = 1'b0;
    check("full_drop", 32'(level), 32'd16);
    out_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      automatic logic [3:0] hi = 4'h1;
      automatic logic [3:0] lo = 4'(k / 2);
      automatic logic [3:0] exp;
      if (LsbFirst) exp = (k % 2 == 0) ? lo : hi;
      else          exp = (k % 2 == 0) ? hi : lo;
      check("fill_drain_nib", 32'(data_out), 32'(exp));
      step();
    end
    out_en = 1'b0;
    check("fill_drain_empty", 32'(out_v), 32'h0);

    // Full threshold with a concurrent read
    for (int i = 0; i < 8; i++) begin
      in_v = 1'b1; data_in = 8'(8'h20 + i);
      step();
    end
    in_v = 1'b0; out_en = 1'b1;
    step();
    check("thr_level15", 32'(level), 32'd15);
    check("thr_in_en15", 32'(in_en), 32'h0);
    in_v = 1'b1; data_in = 8'h77;
    step();
    check("thr_level14", 32'(level), 32'd14);
    check("thr_in_en14", 32'(in_en), 32'h1);
    data_in = 8'hEE;
    step();
    in_v = 1'b0; out_en = 1'b0;
    check("thr_wr_rd_level", 32'(level), 32'd15);
    drain();

    // Streaming with continuous reads; producer holds until accepted
    out_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      automatic bit done = 1'b0;
      in_v = 1'b1; data_in = 8'(i);
      for (int t = 0; t < 20 && !done; t++) begin
        done = in_en;
        step();
      end
      check("stream_accept", 32'(done), 32'h1);
    end
    in_v = 1'b0;
    drain();

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      in_v = 1'b1; data_in = 8'(8'h50 + i);
      step();
    end
    in_v = 1'b0; out_en = 1'b1;
    step();
    out_en = 1'b0;
    check("mid_level5", 32'(level), 32'd5);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_level", 32'(level), 32'h0);
    check("mid_rst_out_v", 32'(out_v), 32'h0);
    in_v = 1'b1; data_in = 8'h3C;
    step();
    in_v = 1'b0; out_en = 1'b1;
    check("post_rst_nib0", 32'(data_out), LsbFirst ? 32'hC : 32'h3);
    step();
    check("post_rst_nib1", 32'(data_out), LsbFirst ? 32'h3 : 32'hC);
    step();
    out_en = 1'b0;
    check("post_rst_empty", 32'(level), 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
